// File: rtl/pnr_window_discriminator.sv
`default_nettype none
// pnr_window_discriminator: trigger -> delay -> integration window -> threshold bin decision.
// Optional per-bin event histogram enabled by defining PNR_HIST_EN.
module pnr_window_discriminator #(
  parameter int DATA_W     = 14,
  parameter int NUM_LEVELS = 8,
  parameter int DLY_W      = 8,
  parameter int WIN_W      = 8,
  parameter int CNT_W      = $clog2(NUM_LEVELS + 1),
  parameter int HIST_W     = 32
) (
  input  logic                         ADC_CLK,
  input  logic                         rst_i,
  input  logic                         trigger_i,
  input  logic [DLY_W-1:0]             delay_i,
  input  logic [WIN_W-1:0]             window_i,
  input  logic                         mode_i,
  input  logic signed [DATA_W-1:0]     sig_i,
  input  logic [NUM_LEVELS*DATA_W-1:0] thresholds_i,
  output logic [NUM_LEVELS:0]          onehot_o,
  output logic [CNT_W-1:0]             count_o,
  output logic                         valid_o,
  output logic                         busy_o,
  output logic [15:0]                  missed_o,
  output logic [DATA_W-1:0]            fifo_data_o,
  output logic                         fifo_wr_en_o,
  input  logic [CNT_W-1:0]             hist_sel_i,
  input  logic                         hist_clr_i,
  output logic [HIST_W-1:0]            hist_data_o
);

  localparam int NBINS = NUM_LEVELS + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DELAY     = 2'd1,
    S_INTEGRATE = 2'd2,
    S_DECIDE    = 2'd3
  } state_t;

  state_t                    state;
  logic [DLY_W-1:0]          dly_cnt;
  logic [WIN_W-1:0]          win_cnt;
  logic                      first;
  logic signed [DATA_W-1:0]  peak;
  logic [CNT_W-1:0]          level;
  logic [WIN_W-1:0]          win_last;

  // Single-sample mode and a zero window both collapse to one window cycle.
  assign win_last = (!mode_i || window_i == '0) ? '0 : window_i - WIN_W'(1);

  always_comb begin
    level = '0;
    for (int k = 0; k < NUM_LEVELS; k++) begin
      if ($signed(thresholds_i[k*DATA_W +: DATA_W]) < peak)
        level = level + CNT_W'(1);
    end
  end

  assign fifo_data_o  = sig_i;
  assign fifo_wr_en_o = (state == S_INTEGRATE);
  assign busy_o       = (state != S_IDLE);

  always_ff @(posedge ADC_CLK) begin
    if (rst_i) begin
      state    <= S_IDLE;
      dly_cnt  <= '0;
      win_cnt  <= '0;
      first    <= 1'b0;
      peak     <= '0;
      onehot_o <= '0;
      count_o  <= '0;
      valid_o  <= 1'b0;
      missed_o <= '0;
    end else begin
      valid_o <= 1'b0;
      if (trigger_i && state != S_IDLE && missed_o != 16'hFFFF)
        missed_o <= missed_o + 16'd1;
      case (state)
        S_IDLE: begin
          if (trigger_i) begin
            onehot_o <= '0;
            count_o  <= '0;
            dly_cnt  <= delay_i - DLY_W'(1);
            win_cnt  <= win_last;
            first    <= 1'b1;
            state    <= (delay_i != '0) ? S_DELAY : S_INTEGRATE;
          end
        end
        S_DELAY: begin
          if (dly_cnt == '0) state <= S_INTEGRATE;
          else               dly_cnt <= dly_cnt - DLY_W'(1);
        end
        S_INTEGRATE: begin
          first <= 1'b0;
          if (first || sig_i > peak) peak <= sig_i;
          if (win_cnt == '0) state <= S_DECIDE;
          else               win_cnt <= win_cnt - WIN_W'(1);
        end
        S_DECIDE: begin
          count_o  <= level;
          onehot_o <= NBINS'(1) << level;
          valid_o  <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PNR_HIST_EN
  logic [HIST_W-1:0] bins [NBINS];

  always_ff @(posedge ADC_CLK) begin
    if (rst_i || hist_clr_i) begin
      for (int b = 0; b < NBINS; b++) bins[b] <= '0;
    end else if (state == S_DECIDE && bins[level] != '1) begin
      bins[level] <= bins[level] + HIST_W'(1);
    end
  end

  always_ff @(posedge ADC_CLK) begin
    if (rst_i)
      hist_data_o <= '0;
    else
      hist_data_o <= (hist_sel_i <= CNT_W'(NUM_LEVELS)) ? bins[hist_sel_i] : '0;
  end
`else
  logic unused_hist;
  assign unused_hist = ^{hist_sel_i, hist_clr_i};
  assign hist_data_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pnr_window_discriminator.sv
`default_nettype none
// Directed self-checking bench for pnr_window_discriminator (thresholds 100..800).
module tb_pnr_window_discriminator;

  logic               clk = 1'b0;
  logic               rst;
  logic               trigger;
  logic [7:0]         delay;
  logic [7:0]         window;
  logic               mode;
  logic signed [13:0] sig;
  logic [111:0]       thr;
  logic [8:0]         onehot;
  logic [3:0]         count;
  logic               valid;
  logic               busy;
  logic [15:0]        missed;
  logic [13:0]        fifo_data;
  logic               fifo_wr_en;
  logic [3:0]         hist_sel;
  logic               hist_clr;
  logic [31:0]        hist_data;

  int n_chk  = 0;
  int n_fail = 0;
  int clr_at = -1;
  logic signed [13:0] smp [8];
  bit hist_on;

  always #5 clk = ~clk;

  pnr_window_discriminator dut (
    .ADC_CLK      (clk),
    .rst_i        (rst),
    .trigger_i    (trigger),
    .delay_i      (delay),
    .window_i     (window),
    .mode_i       (mode),
    .sig_i        (sig),
    .thresholds_i (thr),
    .onehot_o     (onehot),
    .count_o      (count),
    .valid_o      (valid),
    .busy_o       (busy),
    .missed_o     (missed),
    .fifo_data_o  (fifo_data),
    .fifo_wr_en_o (fifo_wr_en),
    .hist_sel_i   (hist_sel),
    .hist_clr_i   (hist_clr),
    .hist_data_o  (hist_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Trigger in cycle T (this negedge), then walk cycle by cycle to the valid cycle.
  // Window cycles carry smp[], all other cycles carry a poison value of 777.
  task automatic run_event(input string tag, input int d, input int w, input bit m,
                           input int exp_cnt, input logic [8:0] exp_oh, input int retrig);
    int weff;
    weff = (m == 1'b0 || w == 0) ? 1 : w;
    @(negedge clk);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    delay = 8'(d); window = 8'(w); mode = m; trigger = 1'b1; sig = 14'sd777;
    for (int i = 1; i <= d + weff + 2; i++) begin
      @(negedge clk);
      trigger  = (i == retrig);
      hist_clr = (i == clr_at);
      sig = (i > d && i <= d + weff) ? smp[i-d-1] : 14'sd777;
      chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, {31'd0, i <= d + weff + 1});
      chk($sformatf("%s_wr%0d", tag, i), {31'd0, fifo_wr_en}, {31'd0, (i > d && i <= d + weff)});
      chk($sformatf("%s_valid%0d", tag, i), {31'd0, valid}, {31'd0, i == d + weff + 2});
      if (i == 1) chk({tag, "_clr"}, {19'd0, count, onehot}, 32'd0);
    end
    hist_clr = 1'b0;
    chk({tag, "_data"}, {18'd0, fifo_data}, {18'd0, 14'd777});
    chk({tag, "_count"}, {28'd0, count}, 32'(exp_cnt));
    chk({tag, "_onehot"}, {23'd0, onehot}, {23'd0, exp_oh});
  endtask

  initial begin
`ifdef PNR_HIST_EN
    hist_on = 1'b1;
`else
    hist_on = 1'b0;
`endif
    for (int k = 0; k < 8; k++) thr[k*14 +: 14] = 14'(100 * (k + 1));
    for (int k = 0; k < 8; k++) smp[k] = 14'sd0;
    rst = 1'b1; trigger = 1'b0; delay = 8'd0; window = 8'd0; mode = 1'b0;
    sig = 14'sd0; hist_sel = 4'd0; hist_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_onehot", {23'd0, onehot}, 32'd0);
    chk("rst_count",  {28'd0, count}, 32'd0);
    chk("rst_valid",  {31'd0, valid}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_missed", {16'd0, missed}, 32'd0);
    chk("rst_wr",     {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_hist",   hist_data, 32'd0);
    rst = 1'b0;

    // Single-sample: only the T+4 sample (250) counts.
    smp[0] = 14'sd250;
    run_event("single", 3, 5, 1'b0, 2, 9'h004, -1);

    // Peak mode with an ignored re-trigger at T+2.
    smp[0] = 14'sd50; smp[1] = 14'sd450; smp[2] = 14'sd300; smp[3] = -14'sd20;
    run_event("peak", 0, 4, 1'b1, 4, 9'h010, 2);
    chk("peak_missed", {16'd0, missed}, 32'd1);

    // Boundaries.
    smp[0] = 14'sd200;
    run_event("eq200", 0, 1, 1'b0, 1, 9'h002, -1);
    smp[0] = 14'h2000;
    run_event("minneg", 0, 1, 1'b0, 0, 9'h001, -1);
    smp[0] = 14'h1FFF;
    run_event("maxpos", 1, 1, 1'b0, 8, 9'h100, -1);
    smp[0] = 14'sd350;
    run_event("win0", 2, 0, 1'b1, 3, 9'h008, -1);

    // Trigger in the valid cycle is accepted; the new window sees constant 777.
    smp[0] = 14'sd50; smp[1] = 14'sd450; smp[2] = 14'sd300; smp[3] = -14'sd20;
    run_event("vtrig", 0, 4, 1'b1, 4, 9'h010, 6);
    @(negedge clk);
    trigger = 1'b0;
    chk("vtrig_clr",  {19'd0, count, onehot}, 32'd0);
    chk("vtrig_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
    chk("vtrig_done", {31'd0, valid}, 32'd1);
    chk("vtrig_count",  {28'd0, count}, 32'd7);
    chk("vtrig_onehot", {23'd0, onehot}, 32'h080);
    chk("vtrig_missed", {16'd0, missed}, 32'd1);

    // Reset during INTEGRATE aborts the event.
    @(negedge clk);
    delay = 8'd1; window = 8'd10; mode = 1'b1; trigger = 1'b1; sig = 14'sd777;
    @(negedge clk);
    trigger = 1'b0;
    @(negedge clk);
    chk("abort_inwin", {31'd0, fifo_wr_en}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",   {31'd0, busy}, 32'd0);
    chk("abort_onehot", {23'd0, onehot}, 32'd0);
    chk("abort_wr",     {31'd0, fifo_wr_en}, 32'd0);
    chk("abort_missed", {16'd0, missed}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("abort_novalid%0d", i), {31'd0, valid}, 32'd0);
      @(negedge clk);
    end
    smp[0] = 14'sd250;
    run_event("after_rst", 3, 5, 1'b0, 2, 9'h004, -1);

    // Histogram: clear, three count-2 events, one count-8 event.
    @(negedge clk);
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    smp[0] = 14'sd250;
    run_event("h2a", 0, 1, 1'b0, 2, 9'h004, -1);
    run_event("h2b", 0, 1, 1'b0, 2, 9'h004, -1);
    run_event("h2c", 0, 1, 1'b0, 2, 9'h004, -1);
    smp[0] = 14'h1FFF;
    run_event("h8", 0, 1, 1'b0, 8, 9'h100, -1);
    hist_sel = 4'd2;
    @(negedge clk);
    chk("hist_bin2", hist_data, hist_on ? 32'd3 : 32'd0);
    hist_sel = 4'd8;
    @(negedge clk);
    chk("hist_bin8", hist_data, hist_on ? 32'd1 : 32'd0);
    hist_sel = 4'd9;
    @(negedge clk);
    chk("hist_sel9", hist_data, 32'd0);
    // Clear raised in the DECIDE cycle (i == 2 for a 1-cycle window with no delay).
    clr_at = 2;
    smp[0] = 14'sd250;
    run_event("hclr", 0, 1, 1'b0, 2, 9'h004, -1);
    clr_at = -1;
    hist_sel = 4'd2;
    @(negedge clk);
    chk("hclr_bin2", hist_data, 32'd0);
    hist_sel = 4'd8;
    @(negedge clk);
    chk("hclr_bin8", hist_data, 32'd0);

    // Saturation of the missed-trigger counter.
    @(negedge clk);
    delay = 8'd255; window = 8'd255; mode = 1'b1; trigger = 1'b1;
    repeat (70000) @(negedge clk);
    trigger = 1'b0;
    chk("missed_sat", {16'd0, missed}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pnr_window_discriminator.md
Name: pnr_window_discriminator

Overview:
Parametrised photon-number-resolving discriminator for the ADC_CLK domain. Each accepted trigger opens a programmable delay, then an integration window. The block captures either a single sample or the window peak, compares it against NUM_LEVELS signed thresholds, and registers a one-hot bin vector plus a binary photon count. Window samples stream to the ADC FIFO, and an optional histogram accumulates events per bin for readout.

Parameters:
DATA_W, 14, ADC sample and threshold width (signed, two's complement)
NUM_LEVELS, 8, threshold count; NUM_LEVELS+1 photon bins
DLY_W, 8, delay counter width
WIN_W, 8, window length counter width
CNT_W, $clog2(NUM_LEVELS+1), count_o width
HIST_W, 32, histogram bin width (PNR_HIST_EN only)

Ports:
ADC_CLK  in  1  clock
rst_i  in  1  synchronous reset, active-high
trigger_i  in  1  start request, level-sampled each cycle
delay_i  in  DLY_W  cycles from trigger to first window sample
window_i  in  WIN_W  window length in cycles; 0 treated as 1
mode_i  in  1  0 = single sample at window start; 1 = peak over window
sig_i  in  DATA_W  signed ADC sample
thresholds_i  in  NUM_LEVELS*DATA_W  threshold k in bits [k*DATA_W +: DATA_W], k=0..NUM_LEVELS-1
onehot_o  out  NUM_LEVELS+1  registered bin vector
count_o  out  CNT_W  registered photon count
valid_o  out  1  one-cycle pulse when onehot_o/count_o update
busy_o  out  1  high in DELAY, INTEGRATE, DECIDE
missed_o  out  16  saturating count of triggers ignored while busy
fifo_data_o  out  DATA_W  equals sig_i
fifo_wr_en_o  out  1  high in each INTEGRATE cycle
hist_sel_i  in  CNT_W  histogram bin select (PNR_HIST_EN only)
hist_clr_i  in  1  clear all bins (PNR_HIST_EN only)
hist_data_o  out  HIST_W  registered bin value (PNR_HIST_EN only)

Behaviour:
- Reset: state IDLE; onehot_o, count_o, valid_o, missed_o, peak, counters and hist_data_o all 0. Reset mid-operation aborts the event, so no valid_o is produced. fifo_wr_en_o is 0 from the next cycle.
- FSM states: IDLE, DELAY, INTEGRATE, DECIDE.
- IDLE: when trigger_i is high in cycle T, the trigger is accepted.
  - onehot_o and count_o clear to 0 at that edge.
  - delay_i, window_i and mode_i are latched.
  - Next state is DELAY if delay_i != 0, otherwise INTEGRATE.
- DELAY: lasts exactly delay_i cycles, then goes to INTEGRATE.
- INTEGRATE: lasts Weff cycles, where Weff = 1 if mode is 0 or window is 0, else window. Window cycles are T+1+D through T+D+Weff.
  - First window sample loads peak directly.
  - Later samples use peak <= max(peak, sig_i), signed.
- DECIDE: one cycle (T+D+Weff+1).
  - c = number of k with threshold_k < peak, signed and strict.
  - count_o <= c; onehot_o <= 1<<c, so exactly one bit is set.
  - valid_o pulses in cycle T+D+Weff+2; state returns to IDLE in that cycle.
- Thresholds are not required to be monotonic; c is always the strict count. For monotonic thresholds, bin 0 means peak <= thr0 and bin NUM_LEVELS means peak > thr(NUM_LEVELS-1).
- thresholds_i is sampled in DECIDE only.
- Outputs hold until the next accepted trigger.
- trigger_i high while busy_o is high: ignored; missed_o increments and saturates at 0xFFFF. A trigger in the valid_o cycle is accepted.
- missed_o clears only on reset.

Optional Feature:
Macro PNR_HIST_EN.
- Defined: NUM_LEVELS+1 bins of HIST_W bits, each saturating at all-ones.
  - On each DECIDE, bin[c] increments.
  - hist_data_o <= bin[hist_sel_i] every cycle (1-cycle read latency). hist_sel_i > NUM_LEVELS reads 0.
  - hist_clr_i zeroes all bins. If hist_clr_i coincides with DECIDE, the clear wins and the event is not counted.
- Undefined: histogram logic is absent, hist_data_o is tied to 0 and hist_sel_i/hist_clr_i are ignored.

Test Plan:
All cases use DATA_W=14, NUM_LEVELS=8, thresholds 100,200,...,800.
1. Single-sample mode: mode 0, delay 3, window 5, trigger at T, sig_i=250 at T+4 -> count_o=2, onehot_o=0x004, valid_o only at T+6; fifo_wr_en_o high only at T+4.
2. Peak mode: mode 1, delay 0, window 4, sig_i 50,450,300,-20 at T+1..T+4 -> peak 450, count_o=4, onehot_o=0x010, valid_o at T+6; fifo_wr_en_o high T+1..T+4.
3. Boundaries: sig_i=200 -> count 1 (strict compare); sig_i=-8192 -> count 0, onehot 0x001; sig_i=8191 -> count 8, onehot 0x100; window_i=0 in mode 1 -> one-sample window.
4. Busy triggers: re-trigger at T+2 in scenario 2 -> ignored, missed_o=1, result unchanged; trigger in valid_o cycle -> accepted, outputs clear next cycle; 70000 busy triggers -> missed_o=0xFFFF.
5. Reset mid-INTEGRATE -> next cycle state IDLE, busy_o=0, onehot_o=0, no valid_o; a following trigger completes normally.
6. PNR_HIST_EN: three events with count 2 and one with count 8, hist_sel_i=2 -> hist_data_o=3 one cycle later; sel=8 -> 1; sel=9 -> 0; hist_clr_i coinciding with DECIDE -> all bins 0.
